// File: rtl/nasti_lite_pkg.sv
// Shared constants and helpers for the NASTI <-> NASTI-lite bridges.
// Holds the response and burst encodings, the FSM state type and the sub-word math.
package nasti_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} rd_state_t;

    // Error codes are numerically larger, so the max is the worst response.
    function automatic logic [1:0] combine_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Number of lite words needed to carry one NASTI beat of 2^size bytes.
    function automatic int lite_packet_size(input logic [2:0] size, input int buf_bytes);
        int bytes;
        bytes = 1 << size;
        return (bytes > buf_bytes) ? bytes / buf_bytes : 1;
    endfunction

endpackage

// File: rtl/nasti_lite_read_buf.sv
// Circular buffer of returned lite words (data, resp, user).
// One word is pushed per lite R handshake; a whole beat of pop_cnt words leaves at once.
module nasti_lite_read_buf #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int MAX_SUB    = 2,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             push,
    input  logic [DATA_WIDTH-1:0]            push_data,
    input  logic [1:0]                       push_resp,
    input  logic [USER_WIDTH-1:0]            push_user,
    input  logic                             pop,
    input  logic [CW-1:0]                    pop_cnt,
    output logic [CW-1:0]                    count,
    output logic [MAX_SUB*DATA_WIDTH-1:0]    rd_data,
    output logic [MAX_SUB*2-1:0]             rd_resp,
    output logic [MAX_SUB*USER_WIDTH-1:0]    rd_user
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [1:0]            resp_mem [DEPTH];
    logic [USER_WIDTH-1:0] user_mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    // Pointer advance that also works for non power-of-two depths.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_add(wr_ptr_reg, 1);
            if (pop)  rd_ptr_reg <= ptr_add(rd_ptr_reg, int'(pop_cnt));
            count_reg <= count_reg + CW'(push) - (pop ? pop_cnt : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= push_data;
            resp_mem[wr_ptr_reg] <= push_resp;
            user_mem[wr_ptr_reg] <= push_user;
        end
    end

    // The oldest MAX_SUB entries are presented side by side for beat assembly.
    generate
        for (genvar gi = 0; gi < MAX_SUB; gi++) begin : g_rd
            logic [PW-1:0] idx;
            assign idx = ptr_add(rd_ptr_reg, gi);
            assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_mem[idx];
            assign rd_resp[gi*2 +: 2]                   = resp_mem[idx];
            assign rd_user[gi*USER_WIDTH +: USER_WIDTH] = user_mem[idx];
        end
    endgenerate

    assign count = count_reg;

endmodule

// File: rtl/nasti_lite_reader.sv
// Splits one NASTI read burst into single-word lite reads and reassembles the
// returned words into NASTI R beats, throttled by a buffer credit count.
module nasti_lite_reader
    import nasti_lite_pkg::*;
#(
    parameter int BUF_DEPTH        = 2,
    parameter int ID_WIDTH         = 1,
    parameter int ADDR_WIDTH       = 8,
    parameter int NASTI_DATA_WIDTH = 8,
    parameter int LITE_DATA_WIDTH  = 32,
    parameter int USER_WIDTH       = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [ID_WIDTH-1:0]         nasti_ar_id,
    input  logic [ADDR_WIDTH-1:0]       nasti_ar_addr,
    input  logic [7:0]                  nasti_ar_len,
    input  logic [2:0]                  nasti_ar_size,
    input  logic [1:0]                  nasti_ar_burst,
    input  logic                        nasti_ar_lock,
    input  logic [3:0]                  nasti_ar_cache,
    input  logic [2:0]                  nasti_ar_prot,
    input  logic [3:0]                  nasti_ar_qos,
    input  logic [3:0]                  nasti_ar_region,
    input  logic [USER_WIDTH-1:0]       nasti_ar_user,
    input  logic                        nasti_ar_valid,
    output logic                        nasti_ar_ready,
    output logic [ID_WIDTH-1:0]         nasti_r_id,
    output logic [NASTI_DATA_WIDTH-1:0] nasti_r_data,
    output logic [1:0]                  nasti_r_resp,
    output logic                        nasti_r_last,
    output logic [USER_WIDTH-1:0]       nasti_r_user,
    output logic                        nasti_r_valid,
    input  logic                        nasti_r_ready,
    output logic [ID_WIDTH-1:0]         lite_ar_id,
    output logic [ADDR_WIDTH-1:0]       lite_ar_addr,
    output logic [2:0]                  lite_ar_prot,
    output logic [3:0]                  lite_ar_qos,
    output logic [3:0]                  lite_ar_region,
    output logic [USER_WIDTH-1:0]       lite_ar_user,
    output logic                        lite_ar_valid,
    input  logic                        lite_ar_ready,
    input  logic [ID_WIDTH-1:0]         lite_r_id,
    input  logic [LITE_DATA_WIDTH-1:0]  lite_r_data,
    input  logic [1:0]                  lite_r_resp,
    input  logic [USER_WIDTH-1:0]       lite_r_user,
    input  logic                        lite_r_valid,
    output logic                        lite_r_ready
);

    localparam int BDW       = (NASTI_DATA_WIDTH < LITE_DATA_WIDTH) ? NASTI_DATA_WIDTH : LITE_DATA_WIDTH;
    localparam int BUF_BYTES = BDW / 8;
    localparam int MAX_SUB   = NASTI_DATA_WIDTH / BDW;
    localparam int NW        = $clog2(256 * MAX_SUB) + 1;
    localparam int CW        = $clog2(BUF_DEPTH + 1);
    localparam int MAX_SIZE  = $clog2(NASTI_DATA_WIDTH / 8);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    generate
        if (!(LITE_DATA_WIDTH == 32 || LITE_DATA_WIDTH == 64)) begin : g_bad_lite_width
            $fatal(1, "LITE_DATA_WIDTH must be 32 or 64");
        end
        if (BUF_DEPTH < MAX_SUB) begin : g_bad_depth
            $fatal(1, "BUF_DEPTH must hold a whole NASTI beat");
        end
    endgenerate

    rd_state_t state_reg, state_next;

    logic [ID_WIDTH-1:0]   id_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]            len_reg;
    logic [1:0]            burst_reg;
    logic [2:0]            prot_reg;
    logic [3:0]            qos_reg;
    logic [3:0]            region_reg;
    logic [USER_WIDTH-1:0] user_reg;
    logic [NW-1:0]         sub_reg, total_reg, issued_reg;
    logic [CW-1:0]         credit_reg;
    logic [7:0]            beat_reg;

    logic ar_hs, lite_ar_hs, lite_r_hs, r_hs;
    logic [NW-1:0] sub_ar, total_ar, word_off;
    logic [CW-1:0] buf_count;
    logic [MAX_SUB*BDW-1:0]        rd_data;
    logic [MAX_SUB*2-1:0]          rd_resp;
    logic [MAX_SUB*USER_WIDTH-1:0] rd_user;

    assign ar_hs      = nasti_ar_valid && nasti_ar_ready;
    assign lite_ar_hs = lite_ar_valid && lite_ar_ready;
    assign lite_r_hs  = lite_r_valid && lite_r_ready;
    assign r_hs       = nasti_r_valid && nasti_r_ready;

    assign sub_ar   = NW'(lite_packet_size(nasti_ar_size, BUF_BYTES));
    assign total_ar = NW'((int'(nasti_ar_len) + 1) * lite_packet_size(nasti_ar_size, BUF_BYTES));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (ar_hs) state_next = ST_BUSY;
            ST_BUSY: if (r_hs && nasti_r_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Credit bounds outstanding words so every lite return always has a free slot.
    always_comb begin
        nasti_ar_ready = (state_reg == ST_IDLE);
        lite_ar_valid  = (state_reg == ST_BUSY) && (issued_reg < total_reg) && (credit_reg < DEPTH_C);
        nasti_r_valid  = (state_reg == ST_BUSY) && (buf_count >= CW'(sub_reg));
        lite_r_ready   = (buf_count < DEPTH_C);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_reg     <= '0;
            addr_reg   <= '0;
            len_reg    <= '0;
            burst_reg  <= '0;
            prot_reg   <= '0;
            qos_reg    <= '0;
            region_reg <= '0;
            user_reg   <= '0;
            sub_reg    <= '0;
            total_reg  <= '0;
            issued_reg <= '0;
            credit_reg <= '0;
            beat_reg   <= '0;
        end else begin
            if (ar_hs) begin
                id_reg     <= nasti_ar_id;
                addr_reg   <= nasti_ar_addr;
                len_reg    <= nasti_ar_len;
                burst_reg  <= nasti_ar_burst;
                prot_reg   <= nasti_ar_prot;
                qos_reg    <= nasti_ar_qos;
                region_reg <= nasti_ar_region;
                user_reg   <= nasti_ar_user;
                sub_reg    <= sub_ar;
                total_reg  <= total_ar;
                issued_reg <= '0;
                beat_reg   <= '0;
            end else begin
                if (lite_ar_hs) issued_reg <= issued_reg + NW'(1);
                if (r_hs)       beat_reg   <= beat_reg + 8'd1;
            end
            credit_reg <= credit_reg + CW'(lite_ar_hs) - (r_hs ? CW'(sub_reg) : CW'(0));
        end
    end

    // WRAP bursts walk upward like INCR; FIXED replays the same beat footprint.
    assign word_off       = (burst_reg == BURST_FIXED) ? (issued_reg & (sub_reg - NW'(1))) : issued_reg;
    assign lite_ar_addr   = addr_reg + ADDR_WIDTH'(int'(word_off) * BUF_BYTES);
    assign lite_ar_id     = id_reg;
    assign lite_ar_prot   = prot_reg;
    assign lite_ar_qos    = qos_reg;
    assign lite_ar_region = region_reg;
    assign lite_ar_user   = user_reg;

    nasti_lite_read_buf #(
        .DEPTH      (BUF_DEPTH),
        .DATA_WIDTH (BDW),
        .USER_WIDTH (USER_WIDTH),
        .MAX_SUB    (MAX_SUB),
        .CW         (CW)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (lite_r_hs),
        .push_data (lite_r_data[BDW-1:0]),
        .push_resp (lite_r_resp),
        .push_user (lite_r_user),
        .pop       (r_hs),
        .pop_cnt   (CW'(sub_reg)),
        .count     (buf_count),
        .rd_data   (rd_data),
        .rd_resp   (rd_resp),
        .rd_user   (rd_user)
    );

    generate
        for (genvar gi = 0; gi < MAX_SUB; gi++) begin : g_lane
            assign nasti_r_data[gi*BDW +: BDW] = (NW'(gi) < sub_reg) ? rd_data[gi*BDW +: BDW] : '0;
        end
    endgenerate

    always_comb begin
        nasti_r_resp = RESP_OKAY;
        nasti_r_user = '0;
        for (int k = 0; k < MAX_SUB; k++) begin
            if (NW'(k) < sub_reg)
                nasti_r_resp = combine_resp(nasti_r_resp, rd_resp[k*2 +: 2]);
            if (NW'(k) == sub_reg - NW'(1))
                nasti_r_user = rd_user[k*USER_WIDTH +: USER_WIDTH];
        end
    end

    assign nasti_r_id   = id_reg;
    assign nasti_r_last = (beat_reg == len_reg);

    logic unused_ok;
    assign unused_ok = &{1'b0, nasti_ar_lock, nasti_ar_cache, lite_r_data, lite_r_id};

    a_size_legal: assert property (@(posedge clk) disable iff (!rstn)
        ar_hs |-> (nasti_ar_size <= 3'(MAX_SIZE)));
    a_rid_match: assert property (@(posedge clk) disable iff (!rstn)
        lite_r_hs |-> (lite_r_id == id_reg));

endmodule

// File: tb/tb_nasti_lite_reader.sv
// Directed bench for nasti_lite_reader with 64-bit NASTI, 32-bit lite and a 2-word buffer.
// A lite responder replays queued words; a monitor records every accepted R beat.
module tb_nasti_lite_reader;
    import nasti_lite_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [0:0]  nasti_ar_id;
    logic [7:0]  nasti_ar_addr, nasti_ar_len;
    logic [2:0]  nasti_ar_size, nasti_ar_prot;
    logic [1:0]  nasti_ar_burst;
    logic        nasti_ar_lock;
    logic [3:0]  nasti_ar_cache, nasti_ar_qos, nasti_ar_region;
    logic [0:0]  nasti_ar_user;
    logic        nasti_ar_valid, nasti_ar_ready;
    logic [0:0]  nasti_r_id, nasti_r_user;
    logic [63:0] nasti_r_data;
    logic [1:0]  nasti_r_resp;
    logic        nasti_r_last, nasti_r_valid, nasti_r_ready;
    logic [0:0]  lite_ar_id, lite_ar_user;
    logic [7:0]  lite_ar_addr;
    logic [2:0]  lite_ar_prot;
    logic [3:0]  lite_ar_qos, lite_ar_region;
    logic        lite_ar_valid, lite_ar_ready;
    logic [0:0]  lite_r_id, lite_r_user;
    logic [31:0] lite_r_data;
    logic [1:0]  lite_r_resp;
    logic        lite_r_valid, lite_r_ready;

    nasti_lite_reader #(
        .BUF_DEPTH(2), .ID_WIDTH(1), .ADDR_WIDTH(8),
        .NASTI_DATA_WIDTH(64), .LITE_DATA_WIDTH(32), .USER_WIDTH(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .nasti_ar_id(nasti_ar_id), .nasti_ar_addr(nasti_ar_addr), .nasti_ar_len(nasti_ar_len),
        .nasti_ar_size(nasti_ar_size), .nasti_ar_burst(nasti_ar_burst), .nasti_ar_lock(nasti_ar_lock),
        .nasti_ar_cache(nasti_ar_cache), .nasti_ar_prot(nasti_ar_prot), .nasti_ar_qos(nasti_ar_qos),
        .nasti_ar_region(nasti_ar_region), .nasti_ar_user(nasti_ar_user),
        .nasti_ar_valid(nasti_ar_valid), .nasti_ar_ready(nasti_ar_ready),
        .nasti_r_id(nasti_r_id), .nasti_r_data(nasti_r_data), .nasti_r_resp(nasti_r_resp),
        .nasti_r_last(nasti_r_last), .nasti_r_user(nasti_r_user),
        .nasti_r_valid(nasti_r_valid), .nasti_r_ready(nasti_r_ready),
        .lite_ar_id(lite_ar_id), .lite_ar_addr(lite_ar_addr), .lite_ar_prot(lite_ar_prot),
        .lite_ar_qos(lite_ar_qos), .lite_ar_region(lite_ar_region), .lite_ar_user(lite_ar_user),
        .lite_ar_valid(lite_ar_valid), .lite_ar_ready(lite_ar_ready),
        .lite_r_id(lite_r_id), .lite_r_data(lite_r_data), .lite_r_resp(lite_r_resp),
        .lite_r_user(lite_r_user), .lite_r_valid(lite_r_valid), .lite_r_ready(lite_r_ready)
    );

    typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic user; logic id; } beat_t;

    rsp_t       rsp_q[$];
    beat_t      beat_q[$];
    logic [7:0] ar_log[$];
    logic       cur_id = 1'b0;
    int checks = 0;
    int errors = 0;

    // Lite responder: answers each accepted lite AR with the next queued word.
    initial begin : lite_slave
        bit ar_fire, r_fire;
        int pending;
        pending = 0;
        lite_ar_ready = 1'b1; lite_r_valid = 1'b0; lite_r_data = '0;
        lite_r_resp = '0; lite_r_user = '0; lite_r_id = '0;
        forever begin
            @(negedge clk);
            ar_fire = rstn && lite_ar_valid && lite_ar_ready;
            r_fire  = rstn && lite_r_valid && lite_r_ready;
            if (ar_fire) ar_log.push_back(lite_ar_addr);
            @(posedge clk);
            #1;
            if (r_fire && rsp_q.size() > 0) begin rsp_q.delete(0); pending--; end
            if (ar_fire) pending++;
            if (!rstn) begin pending = 0; rsp_q.delete(); end
            if (pending > 0 && rsp_q.size() > 0) begin
                lite_r_valid = 1'b1;
                lite_r_data  = rsp_q[0].data;
                lite_r_resp  = rsp_q[0].resp;
                lite_r_user  = rsp_q[0].data[0];
                lite_r_id    = cur_id;
            end else begin
                lite_r_valid = 1'b0;
            end
        end
    end

    initial begin : r_monitor
        forever begin
            @(negedge clk);
            if (rstn && nasti_r_valid && nasti_r_ready)
                beat_q.push_back('{data: nasti_r_data, resp: nasti_r_resp, last: nasti_r_last,
                                   user: nasti_r_user[0], id: nasti_r_id[0]});
        end
    end

    task automatic push_rsp(input logic [31:0] d, input logic [1:0] r);
        rsp_q.push_back('{data: d, resp: r});
    endtask

    task automatic clear_logs();
        ar_log.delete(); beat_q.delete(); rsp_q.delete();
    endtask

    task automatic send_ar(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id);
        int n;
        n = 0;
        @(negedge clk);
        cur_id = id;
        nasti_ar_id = id; nasti_ar_addr = addr; nasti_ar_len = len;
        nasti_ar_size = size; nasti_ar_burst = burst; nasti_ar_valid = 1'b1;
        while (!nasti_ar_ready && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!nasti_ar_ready) begin errors++; $display("FAIL ar_accept addr=%h not accepted", addr); end
        @(posedge clk);
        #1;
        nasti_ar_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        int c;
        c = 0;
        while (beat_q.size() < n && c < 500) begin @(posedge clk); #1; c++; end
        checks++;
        if (beat_q.size() < n) begin
            errors++;
            $display("FAIL %s_beats got %0d required %0d", name, beat_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({nasti_ar_ready, nasti_r_valid, lite_ar_valid, lite_r_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_in {ar_rdy,r_vld,lar_vld,lr_rdy} got %b required 1001",
                     {nasti_ar_ready, nasti_r_valid, lite_ar_valid, lite_r_ready});
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({nasti_ar_ready, nasti_r_valid, lite_ar_valid, lite_r_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_out {ar_rdy,r_vld,lar_vld,lr_rdy} got %b required 1001",
                     {nasti_ar_ready, nasti_r_valid, lite_ar_valid, lite_r_ready});
        end
        $display("test_reset done");
    endtask

    task automatic test_single(input string name);
        clear_logs();
        push_rsp(32'hAAAAAAAA, RESP_OKAY);
        push_rsp(32'h55555555, RESP_OKAY);
        send_ar(8'h10, 8'd0, 3'd3, BURST_INCR, 1'b1);
        wait_beats(1, name);
        checks++;
        if (ar_log.size() != 2 || ar_log[0] !== 8'h10 || ar_log[1] !== 8'h14) begin
            errors++; $display("FAIL %s_addr got %p required 10,14", name, ar_log);
        end
        if (beat_q.size() >= 1) begin
            checks++;
            if (beat_q[0].data !== 64'h55555555AAAAAAAA) begin
                errors++; $display("FAIL %s_data got %h required 55555555aaaaaaaa", name, beat_q[0].data);
            end
            checks++;
            if ({beat_q[0].last, beat_q[0].resp, beat_q[0].id, beat_q[0].user} !== 5'b1_00_1_1) begin
                errors++;
                $display("FAIL %s_ctl {last,resp,id,user} got %b required 10011", name,
                         {beat_q[0].last, beat_q[0].resp, beat_q[0].id, beat_q[0].user});
            end
        end
        $display("%s: beat data=%h", name, nasti_r_data);
    endtask

    task automatic test_burst4();
        logic [63:0] exp;
        clear_logs();
        for (int i = 0; i < 8; i++) push_rsp(32'hC0DE0000 + 32'(i), RESP_OKAY);
        send_ar(8'h40, 8'd3, 3'd3, BURST_INCR, 1'b0);
        wait_beats(4, "burst4");
        checks++;
        if (!nasti_ar_ready) begin errors++; $display("FAIL burst4_ar_ready got 0 required 1"); end
        checks++;
        if (ar_log.size() != 8) begin errors++; $display("FAIL burst4_nreads got %0d required 8", ar_log.size()); end
        for (int i = 0; i < 8 && i < ar_log.size(); i++) begin
            checks++;
            if (ar_log[i] !== 8'h40 + 8'(4*i)) begin
                errors++; $display("FAIL burst4_addr%0d got %h required %h", i, ar_log[i], 8'h40 + 8'(4*i));
            end
        end
        for (int j = 0; j < 4 && j < beat_q.size(); j++) begin
            exp = {32'hC0DE0000 + 32'(2*j+1), 32'hC0DE0000 + 32'(2*j)};
            checks++;
            if (beat_q[j].data !== exp || beat_q[j].last !== (j == 3)) begin
                errors++;
                $display("FAIL burst4_beat%0d got %h/%b required %h/%b", j, beat_q[j].data, beat_q[j].last, exp, j == 3);
            end
        end
        $display("test_burst4: %0d lite reads, %0d beats", ar_log.size(), beat_q.size());
    endtask

    task automatic test_size2();
        clear_logs();
        push_rsp(32'h11111111, RESP_OKAY);
        push_rsp(32'h22222222, RESP_OKAY);
        send_ar(8'h08, 8'd1, 3'd2, BURST_INCR, 1'b1);
        wait_beats(2, "size2");
        checks++;
        if (ar_log.size() != 2 || ar_log[0] !== 8'h08 || ar_log[1] !== 8'h0C) begin
            errors++; $display("FAIL size2_addr got %p required 08,0c", ar_log);
        end
        if (beat_q.size() >= 2) begin
            checks++;
            if (beat_q[0].data !== 64'h0000000011111111 || beat_q[0].last !== 1'b0) begin
                errors++; $display("FAIL size2_beat0 got %h/%b required 0000000011111111/0", beat_q[0].data, beat_q[0].last);
            end
            checks++;
            if (beat_q[1].data !== 64'h0000000022222222 || beat_q[1].last !== 1'b1) begin
                errors++; $display("FAIL size2_beat1 got %h/%b required 0000000022222222/1", beat_q[1].data, beat_q[1].last);
            end
        end
        $display("test_size2: %0d beats", beat_q.size());
    endtask

    task automatic test_resp();
        clear_logs();
        push_rsp(32'h1, RESP_OKAY);
        push_rsp(32'h2, RESP_SLVERR);
        push_rsp(32'h3, RESP_DECERR);
        push_rsp(32'h4, RESP_OKAY);
        send_ar(8'h00, 8'd1, 3'd3, BURST_INCR, 1'b0);
        wait_beats(2, "resp");
        if (beat_q.size() >= 2) begin
            checks++;
            if (beat_q[0].resp !== 2'd2) begin errors++; $display("FAIL resp_slverr got %0d required 2", beat_q[0].resp); end
            checks++;
            if (beat_q[1].resp !== 2'd3) begin errors++; $display("FAIL resp_decerr got %0d required 3", beat_q[1].resp); end
            checks++;
            if ({beat_q[0].id, beat_q[0].user, beat_q[1].user} !== 3'b000) begin
                errors++; $display("FAIL resp_id_user got %b required 000", {beat_q[0].id, beat_q[0].user, beat_q[1].user});
            end
        end
        $display("test_resp: resps checked");
    endtask

    task automatic test_backpressure();
        int c;
        clear_logs();
        for (int i = 0; i < 4; i++) push_rsp(32'h000000B0 + 32'(i), RESP_OKAY);
        nasti_r_ready = 1'b0;
        send_ar(8'h80, 8'd1, 3'd3, BURST_INCR, 1'b1);
        c = 0;
        while (!nasti_r_valid && c < 100) begin @(posedge clk); #1; c++; end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (!nasti_r_valid || nasti_r_data !== 64'h000000B1000000B0 || nasti_r_last !== 1'b0 ||
                nasti_r_resp !== 2'd0 || lite_ar_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_cyc%0d vld=%b data=%h last=%b lar_vld=%b required 1/000000b1000000b0/0/0",
                         k, nasti_r_valid, nasti_r_data, nasti_r_last, lite_ar_valid);
            end
        end
        checks++;
        if (ar_log.size() != 2) begin errors++; $display("FAIL stall_outstanding got %0d required 2", ar_log.size()); end
        nasti_r_ready = 1'b1;
        wait_beats(2, "stall");
        if (beat_q.size() >= 2) begin
            checks++;
            if (beat_q[0].data !== 64'h000000B1000000B0 || beat_q[1].data !== 64'h000000B3000000B2 ||
                beat_q[1].last !== 1'b1) begin
                errors++;
                $display("FAIL stall_release got %h,%h required 000000b1000000b0,000000b3000000b2", beat_q[0].data, beat_q[1].data);
            end
        end
        checks++;
        if (ar_log.size() != 4 || ar_log[2] !== 8'h88 || ar_log[3] !== 8'h8C) begin
            errors++; $display("FAIL stall_addr got %p required 80,84,88,8c", ar_log);
        end
        $display("test_backpressure: %0d beats after release", beat_q.size());
    endtask

    task automatic test_fixed();
        logic [63:0] exp;
        clear_logs();
        for (int i = 0; i < 6; i++) push_rsp(32'h000000F0 + 32'(i), RESP_OKAY);
        send_ar(8'h20, 8'd2, 3'd3, BURST_FIXED, 1'b0);
        wait_beats(3, "fixed");
        checks++;
        if (ar_log.size() != 6) begin errors++; $display("FAIL fixed_nreads got %0d required 6", ar_log.size()); end
        for (int i = 0; i < 6 && i < ar_log.size(); i++) begin
            checks++;
            if (ar_log[i] !== ((i % 2 == 0) ? 8'h20 : 8'h24)) begin
                errors++; $display("FAIL fixed_addr%0d got %h required %h", i, ar_log[i], (i % 2 == 0) ? 8'h20 : 8'h24);
            end
        end
        for (int j = 0; j < 3 && j < beat_q.size(); j++) begin
            exp = {32'h000000F0 + 32'(2*j+1), 32'h000000F0 + 32'(2*j)};
            checks++;
            if (beat_q[j].data !== exp || beat_q[j].last !== (j == 2)) begin
                errors++;
                $display("FAIL fixed_beat%0d got %h/%b required %h/%b", j, beat_q[j].data, beat_q[j].last, exp, j == 2);
            end
        end
        $display("test_fixed: %0d lite reads", ar_log.size());
    endtask

    task automatic test_midreset();
        clear_logs();
        for (int i = 0; i < 8; i++) push_rsp(32'h00000D00 + 32'(i), RESP_OKAY);
        send_ar(8'h40, 8'd3, 3'd3, BURST_INCR, 1'b0);
        wait_beats(1, "midrst");
        rstn = 1'b0;
        #1;
        checks++;
        if ({nasti_ar_ready, nasti_r_valid, lite_ar_valid, lite_r_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL midrst {ar_rdy,r_vld,lar_vld,lr_rdy} got %b required 1001",
                     {nasti_ar_ready, nasti_r_valid, lite_ar_valid, lite_r_ready});
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_midreset: reset taken mid-burst");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nasti_ar_id = '0; nasti_ar_addr = '0; nasti_ar_len = '0; nasti_ar_size = '0;
        nasti_ar_burst = '0; nasti_ar_lock = 1'b0; nasti_ar_cache = '0; nasti_ar_prot = 3'd2;
        nasti_ar_qos = 4'd0; nasti_ar_region = 4'd0; nasti_ar_user = '0; nasti_ar_valid = 1'b0;
        nasti_r_ready = 1'b1;
        test_reset();
        test_single("single");
        test_burst4();
        test_size2();
        test_resp();
        test_backpressure();
        test_fixed();
        test_midreset();
        test_single("after_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
